// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle RV32I sequencer and its datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic [1:0] ALU_src1_sel;
  logic [1:0] ALU_src2_sel;
  logic [3:0] ALU_ctrl;
  logic [2:0] imm_src;
  logic       adr_src;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic [1:0] result_src;
  logic       reg_write;
  logic       halted;

  modport master (
    input  opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
    output ALU_src1_sel, ALU_src2_sel, ALU_ctrl, imm_src, adr_src, mem_req, mem_we,
           ir_write, pc_write, pc_src, result_src, reg_write, halted
  );

  modport slave (
    output opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
    input  ALU_src1_sel, ALU_src2_sel, ALU_ctrl, imm_src, adr_src, mem_req, mem_we,
           ir_write, pc_write, pc_src, result_src, reg_write, halted
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencer of the multi-cycle RV32I core; Mealy outputs, 3-5 cycles per instruction.
// Memory backpressure: FETCH/MEMREAD/MEMWRITE hold with mem_req asserted until mem_ready.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_WB, S_LUI, S_AUIPC, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASS_B = 4'd10;

  localparam logic [1:0] SRC1_PC = 2'd0, SRC1_PC_OLD = 2'd1, SRC1_RS1 = 2'd2;
  localparam logic [1:0] SRC2_RS2 = 2'd0, SRC2_IMM = 2'd1, SRC2_FOUR = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  state_t state, next_state;

  logic [1:0] src1, src2, res;
  logic [3:0] alu;
  logic [2:0] imm;
  logic       adr, req, we, irw, pcw, pcs, rw, hlt;

  // alt only distinguishes SUB and SRA; immediate ops pass alt = 0 for funct3 000.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l,
                                    input logic lu);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = l;
      3'b101:  t = !l;
      3'b110:  t = lu;
      3'b111:  t = !lu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    src1 = SRC1_PC;
    src2 = SRC2_RS2;
    alu  = ALU_ADD;
    imm  = IMM_I;
    adr  = 1'b0;
    req  = 1'b0;
    we   = 1'b0;
    irw  = 1'b0;
    pcw  = 1'b0;
    pcs  = 1'b0;
    res  = 2'd0;
    rw   = 1'b0;
    hlt  = 1'b0;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (bus.mem_ready) begin
          irw  = 1'b1;
          pcw  = 1'b1;
          src2 = SRC2_FOUR;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute PC_old + imm so ALUOut carries the branch/JAL target.
        src1 = SRC1_PC_OLD;
        src2 = SRC2_IMM;
        if (bus.opcode == OP_BRANCH)   imm = IMM_B;
        else if (bus.opcode == OP_JAL) imm = IMM_J;
        case (bus.opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR_ADR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
          default:           next_state = S_HALT;
        endcase
      end
      S_MEMADR: begin
        src1 = SRC1_RS1;
        src2 = SRC2_IMM;
        imm  = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        req = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        res = 2'd1;
        rw  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        req = 1'b1;
        we  = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        src1 = SRC1_RS1;
        src2 = SRC2_RS2;
        alu  = alu_dec(bus.funct3, bus.funct7_5);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        src1 = SRC1_RS1;
        src2 = SRC2_IMM;
        imm  = IMM_I;
        alu  = alu_dec(bus.funct3, bus.funct7_5 && (bus.funct3 != 3'b000));
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        res = 2'd0;
        rw  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        src1 = SRC1_RS1;
        src2 = SRC2_RS2;
        alu  = ALU_SUB;
        pcs  = 1'b1;
        pcw  = br_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
        next_state = S_FETCH;
      end
      S_JAL, S_JALR_WB: begin
        src1 = SRC1_PC_OLD;
        src2 = SRC2_FOUR;
        pcw  = 1'b1;
        pcs  = 1'b1;
        res  = 2'd2;
        rw   = 1'b1;
        next_state = S_FETCH;
      end
      S_JALR_ADR: begin
        src1 = SRC1_RS1;
        src2 = SRC2_IMM;
        imm  = IMM_I;
        next_state = S_JALR_WB;
      end
      S_LUI: begin
        src2 = SRC2_IMM;
        imm  = IMM_U;
        alu  = ALU_PASS_B;
        next_state = S_ALUWB;
      end
      S_AUIPC: begin
        src1 = SRC1_PC_OLD;
        src2 = SRC2_IMM;
        imm  = IMM_U;
        next_state = S_ALUWB;
      end
      S_HALT: begin
        hlt = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign bus.ALU_src1_sel = src1;
  assign bus.ALU_src2_sel = src2;
  assign bus.ALU_ctrl     = alu;
  assign bus.imm_src      = imm;
  assign bus.adr_src      = adr;
  assign bus.pc_src       = pcs;
  assign bus.result_src   = res;
  // Strobes are held off while reset is asserted so nothing fires during reset.
  assign bus.mem_req      = req & rst_n;
  assign bus.mem_we       = we  & rst_n;
  assign bus.ir_write     = irw & rst_n;
  assign bus.pc_write     = pcw & rst_n;
  assign bus.reg_write    = rw  & rst_n;
  assign bus.halted       = hlt & rst_n;

endmodule
